// File: rtl/mem_writeback.sv
// Memory / writeback stage. Non-memory ops retire the cycle after they are
// accepted. Loads and stores hold a data-memory request in MEM until
// dmem_resp arrives. A load writes the register file the cycle after that.
module mem_writeback (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_rs2,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_u_imm,
  input  logic [4:0]  in_rd,
  input  logic [2:0]  in_funct3,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_load_rd,
  input  logic [1:0]  in_wb_sel,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        ld_regfile,
  output logic [4:0]  rd,
  output logic [31:0] wb_data,
  output logic        stall_out
);

  typedef enum logic {IDLE, MEM} state_t;
  state_t state;

  // Instruction fields captured at accept. A load needs them again when
  // the memory response comes back.
  logic [31:0] cap_alu, cap_pc, cap_u_imm;
  logic [4:0]  cap_rd;
  logic [2:0]  cap_funct3;
  logic [1:0]  cap_wb_sel;
  logic        cap_load_rd, cap_read;

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  assign stall_out = (state == MEM);

  function automatic logic [31:0] wb_mux(input logic [1:0] sel, input logic [31:0] alu,
                                         input logic [31:0] mem, input logic [31:0] pc,
                                         input logic [31:0] uimm);
    case (sel)
      2'b00:   wb_mux = alu;
      2'b01:   wb_mux = mem;
      2'b10:   wb_mux = pc + 32'd4;
      default: wb_mux = uimm;
    endcase
  endfunction

  // Store lane steering: replicate the data and enable only the addressed lanes.
  always_comb begin
    st_be    = 4'b0000;
    st_wdata = 32'd0;
    case (in_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << in_alu[1:0];
        st_wdata = {4{in_rs2[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << {in_alu[1], 1'b0};
        st_wdata = {2{in_rs2[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = in_rs2;
      end
    endcase
  end

  // Load extraction: select the addressed byte or halfword, then extend it.
  always_comb begin
    ld_byte = dmem_rdata[{cap_alu[1:0], 3'b000} +: 8];
    ld_half = cap_alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (cap_funct3)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_val = {24'd0, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_val = {16'd0, ld_half};
      default: ld_val = dmem_rdata;
    endcase
  end

  // Stage FSM: accept in IDLE, hold the memory request in MEM, and register all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      ld_regfile       <= 1'b0;
      rd               <= 5'd0;
      wb_data          <= 32'd0;
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_address     <= 32'd0;
      dmem_wdata       <= 32'd0;
      dmem_byte_enable <= 4'd0;
      cap_alu          <= 32'd0;
      cap_pc           <= 32'd0;
      cap_u_imm        <= 32'd0;
      cap_rd           <= 5'd0;
      cap_funct3       <= 3'd0;
      cap_wb_sel       <= 2'd0;
      cap_load_rd      <= 1'b0;
      cap_read         <= 1'b0;
    end else begin
      ld_regfile <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            cap_alu     <= in_alu;
            cap_pc      <= in_pc;
            cap_u_imm   <= in_u_imm;
            cap_rd      <= in_rd;
            cap_funct3  <= in_funct3;
            cap_wb_sel  <= in_wb_sel;
            cap_load_rd <= in_load_rd;
            cap_read    <= in_mem_read;
            if (in_mem_read || in_mem_write) begin
              // When both read and write are set, the op is treated as a load.
              state            <= MEM;
              dmem_read        <= in_mem_read;
              dmem_write       <= in_mem_write & ~in_mem_read;
              dmem_address     <= {in_alu[31:2], 2'b00};
              dmem_wdata       <= in_mem_read ? 32'd0 : st_wdata;
              dmem_byte_enable <= in_mem_read ? 4'd0 : st_be;
            end else begin
              ld_regfile <= in_load_rd && (in_rd != 5'd0);
              rd         <= in_rd;
              wb_data    <= wb_mux(in_wb_sel, in_alu, 32'd0, in_pc, in_u_imm);
            end
          end
        end
        MEM: begin
          if (dmem_resp) begin
            state      <= IDLE;
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            if (cap_read) begin
              ld_regfile <= cap_load_rd && (cap_rd != 5'd0);
              rd         <= cap_rd;
              wb_data    <= wb_mux(cap_wb_sel, cap_alu, ld_val, cap_pc, cap_u_imm);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_writeback.sv
// Bench for mem_writeback: directed and random ops, plus a memory responder
// driven inline. Expected writebacks go into a queue and are popped
// whenever ld_regfile pulses.
module tb_mem_writeback;
  logic        clk = 1'b0;
  logic        rst, in_valid;
  logic [31:0] in_alu, in_rs2, in_pc, in_u_imm;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic        in_mem_read, in_mem_write, in_load_rd;
  logic [1:0]  in_wb_sel;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_address, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_byte_enable;
  logic        dmem_resp, ld_regfile, stall_out;
  logic [4:0]  rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [4:0] rd; logic [31:0] data; } wb_t;
  wb_t exp_q[$];

  always #5 clk = ~clk;

  mem_writeback dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_alu(in_alu), .in_rs2(in_rs2),
    .in_pc(in_pc), .in_u_imm(in_u_imm), .in_rd(in_rd), .in_funct3(in_funct3),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_load_rd(in_load_rd),
    .in_wb_sel(in_wb_sel), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .ld_regfile(ld_regfile), .rd(rd), .wb_data(wb_data), .stall_out(stall_out)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ld_ext(input logic [2:0] f3, input logic [1:0] a,
                                         input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0: b = d[7:0];
      2'd1: b = d[15:8];
      2'd2: b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (f3)
      3'd0: return {{24{b[7]}}, b};
      3'd4: return {24'd0, b};
      3'd1: return {{16{h[15]}}, h};
      3'd5: return {16'd0, h};
      default: return d;
    endcase
  endfunction

  // Scoreboard consumer: every writeback pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (ld_regfile) begin
      chk("wb_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_rd", {27'd0, rd}, {27'd0, e.rd});
        chk("wb_data", wb_data, e.data);
      end
    end
  end

  // Issue one op at a negedge, answer it after lat memory cycles, and
  // return at the negedge where the op's writeback is visible.
  task automatic issue(input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc,
                       input logic [31:0] uimm, input logic [4:0] rdd, input logic [2:0] f3,
                       input logic mr, input logic mw, input logic lrd, input logic [1:0] sel,
                       input int lat, input logic [31:0] rdata);
    logic        memop, exp_ld, exp_wr;
    logic [31:0] memval, exp_wd, exp_data;
    logic [3:0]  exp_be;
    memop  = mr | mw;
    exp_wr = mw & ~mr;
    exp_ld = lrd && (rdd != 5'd0) && !exp_wr;
    memval = mr ? ld_ext(f3, alu[1:0], rdata) : 32'd0;
    case (sel)
      2'b00:   exp_data = alu;
      2'b01:   exp_data = memval;
      2'b10:   exp_data = pc + 32'd4;
      default: exp_data = uimm;
    endcase
    case (f3[1:0])
      2'b00: begin exp_be = 4'b0001 << alu[1:0]; exp_wd = {4{rs2[7:0]}}; end
      2'b01: begin exp_be = alu[1] ? 4'b1100 : 4'b0011; exp_wd = {2{rs2[15:0]}}; end
      default: begin exp_be = 4'b1111; exp_wd = rs2; end
    endcase
    in_alu = alu; in_rs2 = rs2; in_pc = pc; in_u_imm = uimm; in_rd = rdd; in_funct3 = f3;
    in_mem_read = mr; in_mem_write = mw; in_load_rd = lrd; in_wb_sel = sel; in_valid = 1'b1;
    if (exp_ld) exp_q.push_back('{rd: rdd, data: exp_data});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (memop) begin
      for (int k = 0; k < lat; k++) begin
        chk("mem_stall", stall_out, 1);
        chk("mem_read", dmem_read, mr);
        chk("mem_write", dmem_write, exp_wr);
        chk("mem_addr", dmem_address, {alu[31:2], 2'b00});
        chk("mem_noearly_wb", ld_regfile, 0);
        if (exp_wr) begin
          chk("mem_be", {28'd0, dmem_byte_enable}, {28'd0, exp_be});
          chk("mem_wdata", dmem_wdata, exp_wd);
        end
        if (k == lat - 1) begin
          dmem_rdata = rdata;
          dmem_resp  = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        dmem_resp  = 1'b0;
        dmem_rdata = $urandom;
      end
      chk("post_read", dmem_read, 0);
      chk("post_write", dmem_write, 0);
    end
    chk("stall_idle", stall_out, 0);
    chk("ld_regfile", ld_regfile, exp_ld);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_alu = 0; in_rs2 = 0; in_pc = 0; in_u_imm = 0; in_rd = 0;
    in_funct3 = 0; in_mem_read = 0; in_mem_write = 0; in_load_rd = 0; in_wb_sel = 0;
    dmem_rdata = 0; dmem_resp = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ld", ld_regfile, 0);
    chk("rst_rd", {27'd0, rd}, 0);
    chk("rst_wb", wb_data, 0);
    chk("rst_rdstb", dmem_read, 0);
    chk("rst_wrstb", dmem_write, 0);
    chk("rst_addr", dmem_address, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_be", {28'd0, dmem_byte_enable}, 0);
    chk("rst_stall", stall_out, 0);
    rst = 1'b0;

    // Directed ops: ALU, lb with 3 memory cycles, sh, lw to x0, jal wrap, lui
    issue(32'h1234, 0, 0, 0, 5'd5, 3'd0, 0, 0, 1, 2'b00, 0, 0);
    issue(32'h1003, 0, 0, 0, 5'd6, 3'd0, 1, 0, 1, 2'b01, 3, 32'h80FF_FFFF);
    issue(32'h2002, 32'hABCD, 0, 0, 5'd7, 3'd1, 0, 1, 0, 2'b00, 2, 0);
    issue(32'h3000, 0, 0, 0, 5'd0, 3'd2, 1, 0, 1, 2'b01, 1, 32'hDEAD_BEEF);
    issue(32'h55, 0, 32'hFFFF_FFFC, 0, 5'd1, 3'd0, 0, 0, 1, 2'b10, 0, 0);
    issue(32'h66, 0, 0, 32'h1234_5000, 5'd2, 3'd0, 0, 0, 1, 2'b11, 0, 0);
    // Load/store width variants, and read+write set together
    issue(32'h101, 0, 0, 0, 5'd8, 3'd4, 1, 0, 1, 2'b01, 1, 32'h1234_F678);
    issue(32'h102, 0, 0, 0, 5'd9, 3'd1, 1, 0, 1, 2'b01, 2, 32'h8001_7FFF);
    issue(32'h100, 0, 0, 0, 5'd10, 3'd5, 1, 0, 1, 2'b01, 1, 32'h8001_9FFF);
    issue(32'h203, 32'h0000_00A5, 0, 0, 5'd11, 3'd0, 0, 1, 1, 2'b00, 1, 0);
    issue(32'h407, 32'hCAFE_F00D, 0, 0, 5'd12, 3'd2, 0, 1, 0, 2'b00, 1, 0);
    issue(32'h504, 32'h1111_2222, 0, 0, 5'd13, 3'd2, 1, 1, 1, 2'b01, 2, 32'h7777_8888);
    // Load whose writeback source is ALU rather than memory
    issue(32'h600, 0, 0, 0, 5'd14, 3'd2, 1, 0, 1, 2'b00, 1, 32'h9999_9999);

    // Back-to-back ALU ops: one writeback per cycle, no bubble
    for (int i = 0; i < 4; i++) begin
      logic [31:0] v;
      v = $urandom;
      in_alu = v; in_rd = 5'(i + 16); in_mem_read = 0; in_mem_write = 0; in_load_rd = 1;
      in_wb_sel = 2'b00; in_valid = 1'b1;
      exp_q.push_back('{rd: 5'(i + 16), data: v});
      @(posedge clk);
      @(negedge clk);
      chk("b2b_ld", ld_regfile, 1);
      chk("b2b_stall", stall_out, 0);
    end
    in_valid = 1'b0;

    // Reset during MEM aborts the load; a later response is ignored
    in_alu = 32'h700; in_rd = 5'd20; in_funct3 = 3'd2; in_mem_read = 1; in_mem_write = 0;
    in_load_rd = 1; in_wb_sel = 2'b01; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_inmem", stall_out, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_rd", dmem_read, 0);
    chk("abort_stall", stall_out, 0);
    chk("abort_ld", ld_regfile, 0);
    rst = 1'b0; dmem_resp = 1'b1; dmem_rdata = 32'h1;
    @(posedge clk);
    @(negedge clk);
    dmem_resp = 1'b0;
    chk("late_resp_ld", ld_regfile, 0);
    chk("late_resp_stall", stall_out, 0);

    // Reset overrides an accept in the same cycle
    rst = 1'b1; in_valid = 1'b1; in_mem_read = 1; in_alu = 32'h800;
    @(posedge clk);
    @(negedge clk);
    chk("rst_accept_stall", stall_out, 0);
    chk("rst_accept_rd", dmem_read, 0);
    rst = 1'b0; in_valid = 1'b0; in_mem_read = 0;

    // Random mix
    for (int n = 0; n < 30; n++) begin
      int kind;
      logic [2:0] f3;
      logic [1:0] sel;
      kind = $urandom_range(0, 3);
      case ($urandom_range(0, 4))
        0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
      endcase
      case ($urandom_range(0, 2))
        0: sel = 2'b00; 1: sel = 2'b10; default: sel = 2'b11;
      endcase
      if (kind == 1 || kind == 3) sel = 2'b01;
      issue($urandom, $urandom, $urandom, $urandom, 5'($urandom), f3,
            (kind == 1 || kind == 3), (kind == 2 || kind == 3), 1'($urandom),
            sel, $urandom_range(1, 3), $urandom);
    end

    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
